// File: rtl/mult_ctrl_pkg.sv
// Shared types and helpers for the multiplier-sharing controller.
// Operand/product widths, FSM encoding and a constant clog2.
package mult_ctrl_pkg;

    localparam int OPW = 16;
    localparam int PW  = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/mult16x16_array.sv
// Behavioural model of the shared 16x16 unsigned array multiplier.
// Purely combinational; the controller allows it a multicycle settle.
module mult16x16_array (
    input  logic [15:0] A,
    input  logic [15:0] B,
    output logic [31:0] C
);

    assign C = 32'(A) * 32'(B);

endmodule

// File: rtl/mult_share_ctrl_rr_arbiter.sv
// Round-robin arbiter: searches circularly starting just after ptr_i.
// Produces a one-hot grant, its index and an any-grant flag.
module rr_arbiter
    import mult_ctrl_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IW   = clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IW-1:0]   idx_o,
    output logic            any_o
);

    // Walk from farthest to nearest so the nearest requester wins last.
    always_comb begin
        int j;
        j     = 0;
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        for (int k = NREQ; k >= 1; k--) begin
            j = (int'(ptr_i) + k) % NREQ;
            if (req_i[j]) begin
                idx_o = IW'(j);
                any_o = 1'b1;
            end
        end
        gnt_o[idx_o] = any_o;
    end

endmodule

// File: rtl/mult_share_ctrl.sv
// Shares one combinational multiplier among NREQ valid/ready clients.
// Operands are latched on grant; product is registered after LAT cycles.
module mult_share_ctrl
    import mult_ctrl_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int LAT  = 2,
    localparam int IDW = clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [NREQ*16-1:0] req_a,
    input  logic [NREQ*16-1:0] req_b,
    output logic [NREQ-1:0]   req_ready,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [PW-1:0]     res_p,
    output logic [IDW-1:0]    res_id,
    output logic              busy
);

    localparam int CW = (LAT > 1) ? clog2(LAT) : 1;

    state_t         state_q, state_d;
    logic [IDW-1:0] ptr_q, ptr_d;
    logic [IDW-1:0] id_q, id_d;
    logic [OPW-1:0] a_q, a_d;
    logic [OPW-1:0] b_q, b_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           rv_q, rv_d;
    logic [PW-1:0]  rp_q, rp_d;
    logic [IDW-1:0] rid_q, rid_d;

    logic [NREQ-1:0] gnt;
    logic [IDW-1:0]  gidx;
    logic            gany;
    logic [PW-1:0]   prod;

    rr_arbiter #(.NREQ(NREQ), .IW(IDW)) u_arb (
        .req_i (req_valid),
        .ptr_i (ptr_q),
        .gnt_o (gnt),
        .idx_o (gidx),
        .any_o (gany)
    );

    // Inputs come only from the latched operands, never the live buses.
    mult16x16_array u_mul (
        .A (a_q),
        .B (b_q),
        .C (prod)
    );

    // Next-state and handshake logic for the IDLE/MUL/DONE sequence.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        id_d      = id_q;
        a_d       = a_q;
        b_d       = b_q;
        cnt_d     = cnt_q;
        rv_d      = rv_q;
        rp_d      = rp_q;
        rid_d     = rid_q;
        req_ready = '0;
        unique case (state_q)
            IDLE: begin
                req_ready = gnt;
                if (gany) begin
                    a_d     = req_a[int'(gidx)*OPW +: OPW];
                    b_d     = req_b[int'(gidx)*OPW +: OPW];
                    id_d    = gidx;
                    ptr_d   = gidx;
                    cnt_d   = CW'(LAT - 1);
                    state_d = MUL;
                end
            end
            MUL: begin
                if (cnt_q == '0) begin
                    rp_d    = prod;
                    rid_d   = id_q;
                    rv_d    = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                if (res_ready) begin
                    rv_d    = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; reset drops any in-flight operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= IDW'(NREQ - 1);
            id_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cnt_q   <= '0;
            rv_q    <= 1'b0;
            rp_q    <= '0;
            rid_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            a_q     <= a_d;
            b_q     <= b_d;
            cnt_q   <= cnt_d;
            rv_q    <= rv_d;
            rp_q    <= rp_d;
            rid_q   <= rid_d;
        end
    end

    assign res_valid = rv_q;
    assign res_p     = rp_q;
    assign res_id    = rid_q;
    assign busy      = (state_q != IDLE);

endmodule
